// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scanner: segment constants,
// the hex-to-segment lookup (active-high gfedcba) and the scan FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0111111;
         4'h1:    seg = 7'b0000110;
         4'h2:    seg = 7'b1011011;
         4'h3:    seg = 7'b1001111;
         4'h4:    seg = 7'b1100110;
         4'h5:    seg = 7'b1101101;
         4'h6:    seg = 7'b1111101;
         4'h7:    seg = 7'b0000111;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1101111;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b1111100;
         4'hC:    seg = 7'b0111001;
         4'hD:    seg = 7'b1011110;
         4'hE:    seg = 7'b1111001;
         default: seg = 7'b1110001;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit 7-segment driver; the prescaler's slow clock is only
// sampled as data and turned into a one-cycle scan tick in the i_clk domain.
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int BLANK_CYCLES   = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_scan_clk,
   input  logic [4*N_DIGITS-1:0] i_value,
   input  logic [N_DIGITS-1:0]   i_dp,
   input  logic                  i_blank_lz,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [N_DIGITS-1:0]   o_dig,
   output logic                  o_frame
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(BLANK_CYCLES);
   localparam logic [6:0]          SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic                DP_IDLE  = (SEG_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [2:0]            scan_sync_q, scan_sync_d;
   scan_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] snap_val_q, snap_val_d;
   logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   dig_q, dig_d;
   logic                  frame_q, frame_d;

   logic                  tick;
   logic [3:0]            dec_nib;
   logic [6:0]            dec_seg;
   logic [N_DIGITS-1:0]   lz_blank;
   logic                  upper_zero;
   logic [6:0]            seg_on;
   logic                  dp_on;
   logic [N_DIGITS-1:0]   dig_on;

   // Bit 0 and 1 form the synchroniser, bit 2 holds the previous synchronised level.
   assign scan_sync_d = {scan_sync_q[1:0], i_scan_clk};
   assign tick        = scan_sync_q[1] & ~scan_sync_q[2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      snap_val_d = snap_val_q;
      snap_dp_d  = snap_dp_q;
      frame_d    = 1'b0;
      if (tick) begin
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         frame_d = (idx_q == LAST_IDX);
         state_d = BLANK;
         cnt_d   = CNT_LOAD;
      end else if (state_q == BLANK) begin
         if (cnt_q == CNT_W'(1)) begin
            state_d = SHOW;
            if (idx_q == '0) begin
               snap_val_d = i_value;
               snap_dp_d  = i_dp;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Outputs are derived from the next state so they change on the entering edge.
   always_comb begin
      dec_nib = snap_val_d[4*int'(idx_d) +: 4];
   end

   seg7_decode u_decode (
      .i_nib (dec_nib),
      .o_seg (dec_seg)
   );

   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         upper_zero  = upper_zero & (snap_val_d[4*k +: 4] == 4'h0);
         lz_blank[k] = upper_zero;
      end
   end

   always_comb begin
      seg_on = SEG_OFF;
      dp_on  = 1'b0;
      dig_on = '0;
      if (state_d == SHOW) begin
         dig_on[idx_d] = 1'b1;
         dp_on         = snap_dp_d[idx_d];
         if (!(i_blank_lz && lz_blank[idx_d])) begin
            seg_on = dec_seg;
         end
      end
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
      dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_on : dig_on;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scan_sync_q <= '0;
         state_q     <= BLANK;
         cnt_q       <= CNT_LOAD;
         idx_q       <= '0;
         snap_val_q  <= '0;
         snap_dp_q   <= '0;
         seg_q       <= SEG_IDLE;
         dp_q        <= DP_IDLE;
         dig_q       <= DIG_IDLE;
         frame_q     <= 1'b0;
      end else begin
         scan_sync_q <= scan_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         snap_val_q  <= snap_val_d;
         snap_dp_q   <= snap_dp_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         dig_q       <= dig_d;
         frame_q     <= frame_d;
      end
   end

   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_dig   = dig_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised bench for seven_seg_scanner (4 digits, 2 blank cycles, active-low
// outputs) checked every cycle against a behavioural model of the scan rules.
module tb_seven_seg_scanner;

   localparam int N  = 4;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scan = 1'b0;
   logic [15:0] value = 16'h12A0;
   logic [3:0]  dp = 4'b0010;
   logic        lz = 1'b0;
   logic [6:0]  o_seg;
   logic        o_dp;
   logic [3:0]  o_dig;
   logic        o_frame;

   always #5 clk = ~clk;

   seven_seg_scanner #(
      .N_DIGITS       (N),
      .BLANK_CYCLES   (BC),
      .SEG_ACTIVE_LOW (1),
      .DIG_ACTIVE_LOW (1)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_scan_clk (scan),
      .i_value    (value),
      .i_dp       (dp),
      .i_blank_lz (lz),
      .o_seg      (o_seg),
      .o_dp       (o_dp),
      .o_dig      (o_dig),
      .o_frame    (o_frame)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Active-high gfedcba patterns for 0..F
   logic [6:0] seg_table [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   // Behavioural model state
   int          idx;
   int          gap;
   bit          showing;
   logic [15:0] snap_val;
   logic [3:0]  snap_dp;
   bit          h1, h2, h3;
   logic [3:0]  e_dig;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_frame;

   int          cycle;
   int          half_left;
   int          rst_hold;
   int          frames_seen;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s observed=%h expected=%h cycle=%0d time=%0t", tag, observed, expected, cycle, $time);
      end
   endtask

   task automatic model_reset();
      idx      = 0;
      gap      = BC;
      showing  = 1'b0;
      snap_val = '0;
      snap_dp  = '0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      e_dig    = 4'hF;
      e_seg    = 7'h7F;
      e_dp     = 1'b1;
      e_frame  = 1'b0;
   endtask

   task automatic model_step();
      bit          t;
      logic [15:0] upper;
      bit          blanked;
      // A rising edge shows up as a tick two cycles after first being sampled high.
      t  = h2 && !h3;
      h3 = h2;
      h2 = h1;
      h1 = scan;
      e_frame = 1'b0;
      if (t) begin
         e_frame = (idx == N - 1);
         idx     = (idx + 1) % N;
         gap     = BC;
         showing = 1'b0;
      end else if (!showing) begin
         if (gap == 1) begin
            showing = 1'b1;
            if (idx == 0) begin
               snap_val = value;
               snap_dp  = dp;
            end
         end else begin
            gap--;
         end
      end
      if (showing) begin
         upper   = snap_val >> (4 * idx);
         blanked = lz && (idx > 0) && (upper == 16'h0);
         e_dig   = ~(4'b0001 << idx);
         e_seg   = blanked ? 7'h7F : ~seg_table[upper[3:0]];
         e_dp    = ~snap_dp[idx];
      end else begin
         e_dig = 4'hF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end
   endtask

   function automatic logic [15:0] random_value();
      logic [15:0] v;
      logic [15:0] m;
      int          k;
      v = 16'($urandom);
      m = 16'hFFFF;
      k = $urandom_range(0, 4);
      m = m >> (4 * k);
      return v & m;
   endfunction

   task automatic applyStimulus();
      if (rst) begin
         if (rst_hold > 0) rst_hold--;
         if (rst_hold == 0) rst = 1'b0;
      end
      if (cycle >= 40) begin
         half_left--;
         if (half_left <= 0) begin
            scan      = ~scan;
            half_left = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(3, 14);
         end
         if ($urandom_range(0, 15) == 0) value = random_value();
         if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
         if ($urandom_range(0, 63) == 0) lz = ~lz;
      end
   endtask

   initial begin
      model_reset();
      rst_hold    = 3;
      half_left   = 10;
      frames_seen = 0;
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk);
         if (rst) model_reset();
         else     model_step();
         cycle = c;
         #1 applyStimulus();
         @(negedge clk);
         checkOutput("dig", 16'(o_dig), 16'(e_dig));
         checkOutput("seg", 16'(o_seg), 16'(e_seg));
         checkOutput("dp", 16'(o_dp), 16'(e_dp));
         checkOutput("frame", 16'(o_frame), 16'(e_frame));
         if (e_frame) frames_seen++;
         if (!rst && c > 100 && (c == 2000 || $urandom_range(0, 299) == 0)) begin
            #2 rst = 1'b1;
            #1;
            checkOutput("rst_dig", 16'(o_dig), 16'hF);
            checkOutput("rst_seg", 16'(o_seg), 16'h7F);
            checkOutput("rst_dp", 16'(o_dp), 16'h1);
            checkOutput("rst_frame", 16'(o_frame), 16'h0);
            model_reset();
            rst_hold = $urandom_range(1, 3);
         end
      end
      checkOutput("frames_seen_nonzero", 16'(frames_seen > 0), 16'h1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
